axis_pulse_result_averager: RTL and testbench
=============================================

// Module: axis_pulse_result_averager
// PURPOSE
//  Downstream of the pulse-measurement stage. Detects each new pulse result from that
//  stage's case_id/sts_data outputs and averages 2^N consecutive signed results.
//  Emits each average as one AXI-Stream beat, with tlast closing every frame of
//  FRAME_LEN beats. Feeds a DMA/FIFO writer; status word goes to the PS register bank.
// PARAMETERS
//  AXIS_TDATA_WIDTH  32  output beat width; averages are sign-extended to this width
//  ACC_WIDTH         48  signed accumulator width; must be >= 32+16
//  CNTR_WIDTH        16  width of frame-beat and drop counters
// PORTS
//  aclk           in   1   clock
//  aresetn        in   1   asynchronous active-low reset
//  cfg_data       in   32  [4:0] log2 N (values >16 clamp to 16); [8] enable; [31:16] FRAME_LEN (0 acts as 1)
//  case_id        in   3   state index of the measurement stage
//  res_data       in   32  signed pulse result (the measurement stage's sts_data)
//  sts_data       out  32  {drop_cnt[15:0], beat_cnt[15:0]}
//  m_axis_tready  in   1   downstream ready
//  m_axis_tdata   out  AXIS_TDATA_WIDTH  signed average
//  m_axis_tvalid  out  1   output register full
//  m_axis_tlast   out  1   last beat of frame
// BEHAVIOUR
//  Reset (async, aresetn=0): all registers clear immediately, with no clock edge needed.
//   tvalid=0, tlast=0, tdata=0, sts_data=0; accumulator, sample count and case_prev clear.
//  Strobe: case_prev is registered from case_id each cycle.
//   new_res = (case_prev==3'd4) & (case_id==3'd0), which fires for exactly one cycle per pulse.
//   res_data is sampled in the new_res cycle; any other case_id transition is ignored.
//  States:
//   IDLE (enable=0): new_res is ignored; acc=0, cnt=0.
//   ACC (enable=1): on new_res, acc += sext(res_data) and cnt += 1.
//   IDLE -> ACC when enable=1. ACC -> IDLE when enable=0; this clears acc and cnt on the next edge.
//  Window: n is latched from cfg_data[4:0] when cnt==0 and a new_res arrives.
//   A mid-window cfg change takes effect from the next window.
//   The window completes on the new_res that makes cnt==2^n.
//   On completion: avg = (acc + sample) >>> n (arithmetic shift, floor toward -inf).
//   avg is sign-extended to AXIS_TDATA_WIDTH. acc and cnt restart from 0 in the same cycle.
//  Output register (single entry):
//   - Loaded on window completion if empty, or if it is emptying this cycle (tvalid&tready).
//   - Latency: tvalid rises 1 cycle after the completing new_res.
//   - Otherwise the average is dropped; drop_cnt += 1, saturating at 2^CNTR_WIDTH-1.
//   - tdata and tlast hold stable while tvalid=1 and tready=0.
//   - A pending beat is still delivered after enable drops.
//  Frame:
//   - tlast = (beat_cnt == FRAME_LEN-1) at load time; FRAME_LEN is sampled at load.
//   - beat_cnt increments on each tvalid&tready handshake.
//   - beat_cnt wraps to 0 on the handshake of a tlast beat.
//   - beat_cnt resets to 0 when enable=0 and the output register is empty.
//  drop_cnt clears only on reset.
//  Width: acc never overflows for N<=2^16 with 32-bit inputs.
// TESTING
//  1 n=0, FRAME_LEN=4, enable; results 100,-5,7,3 -> beats 100,-5,7,3; tlast only on beat 4; beat_cnt back to 0.
//  2 n=2; results 10,11,12,13 -> one beat 11. Then results -1,-2,-2,-2 -> one beat -2 (floor of -7/4).
//  3 n=0, tready=0; two results -> first held stable, second dropped, drop_cnt=1.
//    Raising tready then delivers the first beat only.
//  4 n=2; 2 results, enable=0 for 1 cycle, then enable=1 and results 4,4,4,4 -> single beat 4 (old partial sum discarded).
//  5 case_id sequences 4->1, 3->0 and 0->0 give no accumulation. A stall at case 4 for 10 cycles then 0 -> exactly one sample.
//  6 aresetn low asynchronously while tvalid=1 -> tvalid=0 and sts_data=0 before the next aclk edge.
//    After release, the next window starts empty.

Source files
------------

// File: rtl/axis_pulse_result_averager.sv
// rtl/axis_pulse_result_averager.sv - averages 2^n pulse results into framed AXI-Stream beats
module axis_pulse_result_averager #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ACC_WIDTH        = 48,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 cfg_data,
  input  logic [2:0]                  case_id,
  input  logic [31:0]                 res_data,
  output logic [31:0]                 sts_data,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t                        r_state;
  logic [2:0]                    r_case_prev;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [16:0]                   r_cnt;
  logic [4:0]                    r_n;
  logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
  logic                          r_tvalid;
  logic                          r_tlast;
  logic [CNTR_WIDTH-1:0]         r_beat_cnt;
  logic [CNTR_WIDTH-1:0]         r_drop_cnt;

  logic                          w_new_res;
  logic                          w_enable;
  logic [4:0]                    w_n_cfg;
  logic [4:0]                    w_n_eff;
  logic signed [ACC_WIDTH-1:0]   w_res_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [ACC_WIDTH-1:0]   w_avg_full;
  logic [16:0]                   w_cnt_inc;
  logic                          w_done;
  logic                          w_hs;
  logic                          w_load;
  logic [CNTR_WIDTH-1:0]         w_beat_next;
  logic [15:0]                   w_flen;
  logic [CNTR_WIDTH-1:0]         w_flen_m1;

  // The measurement stage passes 4 -> 0 exactly once per finished pulse.
  assign w_new_res   = (r_case_prev == 3'd4) && (case_id == 3'd0);
  assign w_enable    = cfg_data[8];
  assign w_n_cfg     = (cfg_data[4:0] > 5'd16) ? 5'd16 : cfg_data[4:0];
  assign w_n_eff     = (r_cnt == 17'd0) ? w_n_cfg : r_n;
  assign w_res_ext   = {{(ACC_WIDTH-32){res_data[31]}}, res_data};
  assign w_sum       = r_acc + w_res_ext;
  assign w_avg_full  = w_sum >>> w_n_eff;
  assign w_cnt_inc   = r_cnt + 17'd1;
  assign w_done      = (r_state == ST_ACC) && w_enable && w_new_res &&
                       (w_cnt_inc == (17'd1 << w_n_eff));
  assign w_hs        = r_tvalid && m_axis_tready;
  assign w_load      = w_done && (!r_tvalid || m_axis_tready);
  assign w_flen      = cfg_data[31:16];
  assign w_flen_m1   = (w_flen == 16'd0) ? '0 : CNTR_WIDTH'(w_flen - 16'd1);

  // Beat count as it will stand after this edge; tlast is judged against it.
  always_comb begin
    w_beat_next = r_beat_cnt;
    if (w_hs) begin
      w_beat_next = r_tlast ? '0 : r_beat_cnt + 1'b1;
    end else if (!w_enable && !r_tvalid) begin
      w_beat_next = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_case_prev <= 3'd0;
      r_acc       <= '0;
      r_cnt       <= 17'd0;
      r_n         <= 5'd0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_beat_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_case_prev <= case_id;
      r_beat_cnt  <= w_beat_next;

      case (r_state)
        ST_IDLE: begin
          r_acc <= '0;
          r_cnt <= 17'd0;
          if (w_enable) r_state <= ST_ACC;
        end
        ST_ACC: begin
          if (!w_enable) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= 17'd0;
          end else if (w_new_res) begin
            if (r_cnt == 17'd0) r_n <= w_n_cfg;
            if (w_done) begin
              r_acc <= '0;
              r_cnt <= 17'd0;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_load) begin
        r_tdata  <= w_avg_full[AXIS_TDATA_WIDTH-1:0];
        r_tvalid <= 1'b1;
        r_tlast  <= (w_beat_next == w_flen_m1);
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
      end

      if (w_done && !w_load && (r_drop_cnt != {CNTR_WIDTH{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign sts_data      = {r_drop_cnt[15:0], r_beat_cnt[15:0]};
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_pulse_result_averager.sv
// tb/tb_axis_pulse_result_averager.sv - directed self-checking bench for the pulse result averager
module tb_axis_pulse_result_averager;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cfg_data;
  logic [2:0]  case_id;
  logic [31:0] res_data;
  logic [31:0] sts_data;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;

  int errors = 0;
  int checks = 0;

  axis_pulse_result_averager dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .case_id       (case_id),
    .res_data      (res_data),
    .sts_data      (sts_data),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One measurement-stage pulse: case 4 for a cycle, then case 0 carrying the result.
  task automatic pulse(input logic [31:0] v);
    case_id  = 3'd4;
    tick();
    case_id  = 3'd0;
    res_data = v;
    tick();
  endtask

  function automatic logic [31:0] cfg(input logic [15:0] flen, input logic en, input logic [4:0] n);
    return {flen, 7'd0, en, 3'd0, n};
  endfunction

  initial begin
    aresetn       = 1'b0;
    cfg_data      = 32'd0;
    case_id       = 3'd0;
    res_data      = 32'd0;
    m_axis_tready = 1'b1;
    tick();
    check("reset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("reset_sts", sts_data, 32'd0);
    check("reset_tdata", m_axis_tdata, 32'd0);
    aresetn = 1'b1;

    // 1: n=0, frame of 4
    cfg_data = cfg(16'd4, 1'b1, 5'd0);
    tick(); tick();
    pulse(32'd100);
    check("t1_b1_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t1_b1_data", m_axis_tdata, 32'd100);
    check("t1_b1_last", {31'd0, m_axis_tlast}, 32'd0);
    pulse(-32'sd5);
    check("t1_b2_data", m_axis_tdata, 32'hFFFF_FFFB);
    check("t1_b2_last", {31'd0, m_axis_tlast}, 32'd0);
    check("t1_beat1", sts_data, 32'h0000_0001);
    pulse(32'd7);
    check("t1_b3_data", m_axis_tdata, 32'd7);
    check("t1_b3_last", {31'd0, m_axis_tlast}, 32'd0);
    pulse(32'd3);
    check("t1_b4_data", m_axis_tdata, 32'd3);
    check("t1_b4_last", {31'd0, m_axis_tlast}, 32'd1);
    tick();
    check("t1_wrap_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t1_wrap_sts", sts_data, 32'd0);

    // 2: n=2 windows
    cfg_data = cfg(16'd4, 1'b1, 5'd2);
    tick();
    pulse(32'd10); pulse(32'd11); pulse(32'd12);
    check("t2_partial_valid", {31'd0, m_axis_tvalid}, 32'd0);
    pulse(32'd13);
    check("t2_w1_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t2_w1_data", m_axis_tdata, 32'd11);
    pulse(-32'sd1); pulse(-32'sd2); pulse(-32'sd2); pulse(-32'sd2);
    check("t2_w2_data", m_axis_tdata, 32'hFFFF_FFFE);
    check("t2_w2_last", {31'd0, m_axis_tlast}, 32'd0);
    tick();
    check("t2_sts", sts_data, 32'h0000_0002);

    // 3: backpressure and drop
    cfg_data      = cfg(16'd4, 1'b1, 5'd0);
    m_axis_tready = 1'b0;
    tick();
    pulse(-32'sd3);
    check("t3_first_data", m_axis_tdata, 32'hFFFF_FFFD);
    pulse(32'd9);
    check("t3_held_data", m_axis_tdata, 32'hFFFF_FFFD);
    check("t3_held_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t3_drop_sts", sts_data, 32'h0001_0002);
    m_axis_tready = 1'b1;
    tick();
    check("t3_deliver_valid", {31'd0, m_axis_tvalid}, 32'd0);
    tick();
    check("t3_no_second", {31'd0, m_axis_tvalid}, 32'd0);
    check("t3_sts", sts_data, 32'h0001_0003);

    // 4: disable discards partial window
    cfg_data = cfg(16'd4, 1'b1, 5'd2);
    tick();
    pulse(32'd1); pulse(32'd2);
    cfg_data = cfg(16'd4, 1'b0, 5'd2);
    tick();
    check("t4_beat_clear", sts_data, 32'h0001_0000);
    cfg_data = cfg(16'd4, 1'b1, 5'd2);
    tick();
    pulse(32'd4); pulse(32'd4); pulse(32'd4);
    check("t4_partial_valid", {31'd0, m_axis_tvalid}, 32'd0);
    pulse(32'd4);
    check("t4_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t4_data", m_axis_tdata, 32'd4);
    tick();
    check("t4_sts", sts_data, 32'h0001_0001);

    // 5: only the 4 -> 0 transition counts
    cfg_data = cfg(16'd4, 1'b1, 5'd0);
    tick();
    case_id = 3'd4; tick();
    case_id = 3'd1; res_data = 32'd77; tick(); tick();
    check("t5_4to1", {31'd0, m_axis_tvalid}, 32'd0);
    case_id = 3'd3; tick();
    case_id = 3'd0; tick(); tick();
    check("t5_3to0", {31'd0, m_axis_tvalid}, 32'd0);
    tick(); tick();
    check("t5_0to0", {31'd0, m_axis_tvalid}, 32'd0);
    case_id = 3'd4;
    for (int i = 0; i < 10; i++) tick();
    check("t5_stall", {31'd0, m_axis_tvalid}, 32'd0);
    case_id = 3'd0; res_data = 32'd55; tick();
    check("t5_one_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t5_one_data", m_axis_tdata, 32'd55);
    tick(); tick(); tick();
    check("t5_only_one", {31'd0, m_axis_tvalid}, 32'd0);
    check("t5_sts", sts_data, 32'h0001_0002);

    // 6: asynchronous reset with a beat pending
    m_axis_tready = 1'b0;
    pulse(32'd8);
    check("t6_pending", {31'd0, m_axis_tvalid}, 32'd1);
    cfg_data = cfg(16'd4, 1'b1, 5'd2);
    pulse(32'd1000);
    aresetn = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t6_async_sts", sts_data, 32'd0);
    check("t6_async_data", m_axis_tdata, 32'd0);
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    pulse(32'd20); pulse(32'd20); pulse(32'd20);
    check("t6_partial_valid", {31'd0, m_axis_tvalid}, 32'd0);
    pulse(32'd20);
    check("t6_fresh_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t6_fresh_data", m_axis_tdata, 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
